// File: rtl/vision_msg_poller.sv
// Avalon-MM master for the image-processor register slave: ID check, periodic status poll,
// bounded message drain onto a valid/ready object stream. Optional macro: VISION_POLL_FILTER_EN.
module vision_msg_poller #(
  parameter int unsigned POLL_INTERVAL = 4096,
  parameter int unsigned MAX_BURST     = 8,
  parameter logic [31:0] ID_VALUE      = 32'h1234EEE2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        flush_req,
  output logic        m_chipselect,
  output logic        m_read,
  output logic        m_write,
  output logic [2:0]  m_address,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  output logic        obj_valid,
  input  logic        obj_ready,
  output logic [2:0]  obj_colour,
  output logic [10:0] obj_xmin,
  output logic [10:0] obj_xmax,
  output logic        obj_present,
  output logic        id_ok,
  output logic [7:0]  bad_tag_cnt,
  output logic [3:0]  dbg_state
);

  localparam int unsigned TW = $clog2(POLL_INTERVAL);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(POLL_INTERVAL - 1);
  localparam logic [7:0]    BURST_LIMIT  = 8'(MAX_BURST);

  typedef enum logic [3:0] {
    ID_RD, ID_WAIT, ERR, IDLE, FLUSH, ST_RD, ST_WAIT, MSG_RD, MSG_WAIT, OUT
  } state_t;

  state_t        state, state_next;
  logic [TW-1:0] timer;
  logic [7:0]    remain;
  logic          flush_pend;

  logic [4:0]  msg_tag;
  logic [10:0] msg_xmin, msg_xmax;
  logic [7:0]  status_n;
  logic        tag_valid, msg_forward, msg_last, timer_zero;

  logic reload_timer, count_timer, load_remain, dec_remain;
  logic capture_obj, bad_tag, set_id_ok, clr_flush;

  assign msg_tag    = m_readdata[31:27];
  assign msg_xmin   = m_readdata[26:16];
  assign msg_xmax   = m_readdata[10:0];
  assign status_n   = m_readdata[15:8];
  assign tag_valid  = (msg_tag >= 5'd1) && (msg_tag <= 5'd6);
  assign msg_last   = (remain == 8'd1);
  assign timer_zero = (timer == '0);

`ifdef VISION_POLL_FILTER_EN
  assign msg_forward = tag_valid && (msg_xmin <= msg_xmax);
`else
  assign msg_forward = tag_valid;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ID_RD;
    else          state <= state_next;
  end

  // Object stream: obj_valid is high throughout OUT and the record fields are frozen there;
  // a record transfers on the rising edge where obj_valid and obj_ready are both high.
  always_comb begin
    state_next   = state;
    reload_timer = 1'b0;
    count_timer  = 1'b0;
    load_remain  = 1'b0;
    dec_remain   = 1'b0;
    capture_obj  = 1'b0;
    bad_tag      = 1'b0;
    set_id_ok    = 1'b0;
    clr_flush    = 1'b0;
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_address    = 3'd0;
    m_writedata  = 32'd0;
    case (state)
      ID_RD: begin
        m_read     = 1'b1;
        m_address  = 3'd2;
        state_next = ID_WAIT;
      end
      ID_WAIT: begin
        reload_timer = 1'b1;
        if (m_readdata == ID_VALUE) begin
          set_id_ok  = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = ERR;
        end
      end
      ERR: begin
        count_timer = 1'b1;
        if (timer_zero) state_next = ID_RD;
      end
      IDLE: begin
        count_timer = 1'b1;
        if (flush_pend)                state_next = FLUSH;
        else if (timer_zero && enable) state_next = ST_RD;
      end
      FLUSH: begin
        m_write     = 1'b1;
        m_writedata = 32'h10;
        clr_flush   = 1'b1;
        state_next  = IDLE;
      end
      ST_RD: begin
        m_read     = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (status_n == 8'd0) begin
          reload_timer = 1'b1;
          state_next   = IDLE;
        end else begin
          load_remain = 1'b1;
          state_next  = MSG_RD;
        end
      end
      MSG_RD: begin
        m_read     = 1'b1;
        m_address  = 3'd1;
        state_next = MSG_WAIT;
      end
      MSG_WAIT: begin
        if (msg_forward) begin
          capture_obj = 1'b1;
          state_next  = OUT;
        end else begin
          // Dropped messages still consume one slot of the burst.
          bad_tag      = !tag_valid;
          dec_remain   = 1'b1;
          reload_timer = msg_last;
          state_next   = msg_last ? IDLE : MSG_RD;
        end
      end
      OUT: begin
        if (obj_ready) begin
          dec_remain   = 1'b1;
          reload_timer = msg_last;
          state_next   = msg_last ? IDLE : MSG_RD;
        end
      end
      default: state_next = ID_RD;
    endcase
    if (!reset_n) begin
      m_read      = 1'b0;
      m_write     = 1'b0;
      m_address   = 3'd0;
      m_writedata = 32'd0;
    end
  end

  assign m_chipselect = m_read | m_write;
  assign obj_valid    = reset_n && (state == OUT);
  assign dbg_state    = state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      timer       <= TIMER_RELOAD;
      remain      <= 8'd0;
      flush_pend  <= 1'b0;
      id_ok       <= 1'b0;
      bad_tag_cnt <= 8'd0;
      obj_colour  <= 3'd0;
      obj_xmin    <= 11'd0;
      obj_xmax    <= 11'd0;
      obj_present <= 1'b0;
    end else begin
      // A request landing in the FLUSH cycle re-arms the latch instead of being cleared.
      flush_pend <= (flush_pend && !clr_flush) || flush_req;
      if (reload_timer)                   timer <= TIMER_RELOAD;
      else if (count_timer && !timer_zero) timer <= timer - TW'(1);
      if (load_remain)
        remain <= (status_n > BURST_LIMIT) ? BURST_LIMIT : status_n;
      else if (dec_remain)
        remain <= remain - 8'd1;
      if (set_id_ok) id_ok <= 1'b1;
      if (bad_tag && bad_tag_cnt != 8'hFF) bad_tag_cnt <= bad_tag_cnt + 8'd1;
      if (capture_obj) begin
        obj_colour  <= msg_tag[2:0];
        obj_xmin    <= msg_xmin;
        obj_xmax    <= msg_xmax;
        obj_present <= (msg_xmin <= msg_xmax);
      end
    end
  end

endmodule
